movavg_norm: RTL and testbench

- Downstream stage of the 4-tap 64-bit moving-sum datapath. Consumes one raw sum per `sum_valid` and divides it by 4 (optional round-half-up).
- Suppresses the warm-up sums that the upstream stage produces while its taps are still zero after reset.
- Buffers results in a small FIFO with a valid/ready output, because the upstream stage cannot be stalled.
- Counts and flags inputs lost to a full FIFO.

---
 rtl/movavg_pkg.sv | 10 +
 rtl/movavg_fifo.sv | 48 ++++
 rtl/movavg_norm.sv | 78 +++++++
 tb/tb_movavg_norm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/movavg_pkg.sv
// Shared constants and types for the 4-tap moving-sum datapath.
// Used by the upstream sum stage and the normalising output stage.
package movavg_pkg;
  localparam int SUM_W = 64;
  localparam int NTAPS = 4;
  localparam int WARMUP_SAMPLES = NTAPS - 1;
  localparam int NORM_SHIFT = 2;

  typedef logic [SUM_W-1:0] sum_t;
endpackage

// File: rtl/movavg_fifo.sv
// Small synchronous FIFO with occupancy count.
// Head data reads as zero while the FIFO is empty.
module movavg_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign empty = (level == '0);
  assign full = (level == LW'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10: level <= level + LW'(1);
        2'b01: level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/movavg_norm.sv
// Divide-by-4 normaliser with warm-up suppression, output FIFO
// and drop statistics for the non-stallable moving-sum stage.
module movavg_norm
  import movavg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROUND = 0,
  parameter int DROP_WARMUP = 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  sum_t          sum_in,
  input  logic          sum_valid,
  output sum_t          avg_out,
  output logic          avg_valid,
  input  logic          avg_ready,
  output logic [LW-1:0] level,
  output logic [15:0]   drop_cnt,
  output logic          overflow,
  input  logic          clr_stat
);
  logic [1:0]       warm;
  logic             warm_ok;
  logic [SUM_W:0]   ext;
  sum_t             norm;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;

  assign warm_ok = (DROP_WARMUP == 0) || (warm == 2'(WARMUP_SAMPLES));
  assign ext = {1'b0, sum_in} + (SUM_W+1)'(ROUND != 0 ? 2 : 0);
  assign norm = SUM_W'(ext >> NORM_SHIFT);
  assign avg_valid = !empty;
  assign pop = avg_valid && avg_ready;
  assign push = sum_valid && warm_ok && (!full || pop);
  assign drop = sum_valid && warm_ok && full && !pop;

  movavg_fifo #(
    .DEPTH(DEPTH),
    .W(SUM_W)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(norm),
    .rdata(avg_out),
    .level(level),
    .full(full),
    .empty(empty)
  );

  // Warm-up counter tracks upstream tap fill; saturates once primed.
  always_ff @(posedge clk) begin
    if (reset) warm <= '0;
    else if (sum_valid && warm != 2'(WARMUP_SAMPLES)) warm <= warm + 2'd1;
  end

  // Drop statistics; a drop in the clear cycle lands after the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (clr_stat) drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (clr_stat) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_movavg_norm.sv
// Self-checking bench for movavg_norm: vector tables, corner
// sequences and randomized traffic against a queue-based model.
module tb_movavg_norm;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        reset;
  logic [63:0] sum_in;
  logic        sum_valid;
  logic [63:0] avg_out;
  logic        avg_valid;
  logic        avg_ready;
  logic [2:0]  level;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        clr_stat;

  logic [63:0] s1;
  logic        v1;
  logic [63:0] a1;
  logic        av1;
  logic [2:0]  l1;
  logic [15:0] d1;
  logic        o1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  movavg_norm #(.DEPTH(DEPTH), .ROUND(0), .DROP_WARMUP(1)) dut (
    .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid),
    .avg_out(avg_out), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .level(level), .drop_cnt(drop_cnt), .overflow(overflow),
    .clr_stat(clr_stat)
  );

  movavg_norm #(.DEPTH(DEPTH), .ROUND(1), .DROP_WARMUP(0)) dut_r (
    .clk(clk), .reset(reset), .sum_in(s1), .sum_valid(v1),
    .avg_out(a1), .avg_valid(av1), .avg_ready(1'b1),
    .level(l1), .drop_cnt(d1), .overflow(o1), .clr_stat(1'b0)
  );

  // reference model of dut (ROUND=0, DROP_WARMUP=1)
  logic [63:0] mq[$];
  int m_warm;
  int m_drops;
  bit m_ovf;

  function automatic logic [63:0] ref_norm(logic [63:0] s, int rnd);
    logic [64:0] t;
    t = {1'b0, s} + 65'(rnd);
    t = t / 4;
    return t[63:0];
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_warm = 0;
    m_drops = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge(bit v, logic [63:0] s, bit r, bit c);
    bit popped;
    popped = (mq.size() > 0) && r;
    if (c) begin
      m_drops = 0;
      m_ovf = 0;
    end
    if (popped) void'(mq.pop_front());
    if (v && m_warm >= 3) begin
      if (mq.size() < DEPTH) mq.push_back(ref_norm(s, 0));
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (v && m_warm < 3) m_warm++;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".valid"}, 64'(avg_valid), 64'(mq.size() > 0));
    chk({tag, ".avg"}, avg_out, (mq.size() > 0) ? mq[0] : 64'd0);
    chk({tag, ".level"}, 64'(level), 64'(mq.size()));
    chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drops));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  // one clock: inputs already stable; sample #1 after the edge
  task automatic step(bit v, logic [63:0] s, bit r, bit c);
    sum_valid = v;
    sum_in = s;
    avg_ready = r;
    clr_stat = c;
    @(posedge clk);
    model_edge(v, s, r, c);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    sum_valid = 0;
    clr_stat = 0;
    v1 = 0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 0;
  endtask

  typedef struct {
    bit          v;
    logic [63:0] s;
    bit          r;
    bit          c;
    bit          e_valid;
    logic [63:0] e_avg;
    int          e_lvl;
    int          e_drop;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1;
    sum_in = 0;
    sum_valid = 0;
    avg_ready = 1;
    clr_stat = 0;
    s1 = 0;
    v1 = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("reset.valid", 64'(avg_valid), 64'd0);
    chk("reset.level", 64'(level), 64'd0);
    chk("reset.avg", avg_out, 64'd0);
    chk("reset.drop", 64'(drop_cnt), 64'd0);
    chk("reset.ovf", 64'(overflow), 64'd0);

    // warm-up suppression, then fill past full and drain
    tbl = '{
      '{1, 4,   1, 0, 0, 0,   0, 0, 0},
      '{1, 12,  1, 0, 0, 0,   0, 0, 0},
      '{1, 24,  1, 0, 0, 0,   0, 0, 0},
      '{1, 40,  1, 0, 1, 10,  1, 0, 0},
      '{1, 56,  1, 0, 1, 14,  1, 0, 0},
      '{0, 0,   1, 0, 0, 0,   0, 0, 0},
      '{1, 100, 0, 0, 1, 25,  1, 0, 0},
      '{1, 200, 0, 0, 1, 25,  2, 0, 0},
      '{1, 300, 0, 0, 1, 25,  3, 0, 0},
      '{1, 400, 0, 0, 1, 25,  4, 0, 0},
      '{1, 500, 0, 0, 1, 25,  4, 1, 1},
      '{1, 600, 0, 0, 1, 25,  4, 2, 1},
      '{0, 0,   0, 0, 1, 25,  4, 2, 1},
      '{0, 0,   1, 0, 1, 50,  3, 2, 1},
      '{0, 0,   1, 0, 1, 75,  2, 2, 1},
      '{0, 0,   1, 0, 1, 100, 1, 2, 1},
      '{0, 0,   1, 0, 0, 0,   0, 2, 1}
    };
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d.valid", i), 64'(avg_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.avg", i), avg_out, tbl[i].e_avg);
      chk($sformatf("tbl%0d.level", i), 64'(level), 64'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d.drop", i), 64'(drop_cnt), 64'(tbl[i].e_drop));
      chk($sformatf("tbl%0d.ovf", i), 64'(overflow), 64'(tbl[i].e_ovf));
    end

    // truncating all-ones sum
    step(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    chk("trunc.ones", avg_out, 64'h3FFF_FFFF_FFFF_FFFF);
    step(0, 0, 1, 0);

    // full with push and pop in the same cycle
    for (int i = 1; i <= 4; i++) step(1, 64'(i * 8), 0, 1);
    chk("full.level", 64'(level), 64'd4);
    chk("full.drop", 64'(drop_cnt), 64'd0);
    step(1, 64'd80, 1, 0);
    chk("pp.level", 64'(level), 64'd4);
    chk("pp.drop", 64'(drop_cnt), 64'd0);
    chk("pp.ovf", 64'(overflow), 64'd0);
    chk("pp.head", avg_out, 64'd4);
    chk_model("pp");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      chk_model("ppdrain");
    end
    chk("ppdrain.tail", 64'(avg_valid), 64'd0);

    // head stable under backpressure
    step(1, 64'd400, 0, 0);
    step(1, 64'd800, 0, 0);
    step(0, 0, 0, 0);
    chk("hold.avg", avg_out, 64'd100);
    chk("hold.level", 64'(level), 64'd2);

    // reset mid-stream with level 3, warm-up restarts
    step(1, 64'd1200, 0, 0);
    chk("pre_rst.level", 64'(level), 64'd3);
    do_reset();
    chk("rst.valid", 64'(avg_valid), 64'd0);
    chk("rst.level", 64'(level), 64'd0);
    avg_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step(1, 64'(1000 + i), 1, 0);
      chk($sformatf("rst.warm%0d", i), 64'(avg_valid), 64'd0);
    end
    step(1, 64'd2000, 1, 0);
    chk("rst.fourth.valid", 64'(avg_valid), 64'd1);
    chk("rst.fourth.avg", avg_out, 64'd500);
    step(0, 0, 1, 0);

    // rounding instance (always ready, no warm-up)
    do_reset();
    v1 = 1; s1 = 64'd6;
    @(posedge clk); #1;
    chk("rnd.6", a1, 64'd2);
    s1 = 64'd5;
    @(posedge clk); #1;
    chk("rnd.5", a1, 64'd1);
    s1 = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    chk("rnd.ones", a1, 64'h4000_0000_0000_0000);
    s1 = 64'd9;
    @(posedge clk); #1;
    chk("rnd.9", a1, 64'd2);
    chk("rnd.level", 64'(l1), 64'd1);
    v1 = 0;
    @(posedge clk); #1;
    chk("rnd.empty", 64'(av1), 64'd0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 60),
           {$urandom, $urandom},
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 3));
      chk_model("rand");
    end

    // saturate the drop counter, then clear
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 64'(i), 0, 0);
    for (int i = 0; i < 65540; i++) step(1, 64'd44, 0, 0);
    chk("sat.drop", 64'(drop_cnt), 64'hFFFF);
    chk("sat.ovf", 64'(overflow), 64'd1);
    step(1, 64'd44, 0, 0);
    chk("sat.hold", 64'(drop_cnt), 64'hFFFF);
    step(0, 0, 0, 1);
    chk("clr.drop", 64'(drop_cnt), 64'd0);
    chk("clr.ovf", 64'(overflow), 64'd0);
    step(1, 64'd44, 0, 1);
    chk("clrdrop.drop", 64'(drop_cnt), 64'd1);
    chk("clrdrop.ovf", 64'(overflow), 64'd1);
    chk_model("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
